// File: rtl/ucsbece154b_burst_pusher.sv
// Burst pusher: fetches BURST_LEN words critical-word-first (wrap-around
// within the aligned block) one at a time from a single-word memory port and
// pushes each word into a downstream FIFO.
module ucsbece154b_burst_pusher #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  push_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  full_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      PUSH = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   // State and datapath registers; reset abandons any burst in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         data_q  <= data_d;
      end
   end

   // Read address: only the word-index field inside the burst block advances,
   // so the sequence wraps around the aligned block starting at the critical word.
   always_comb begin
      mem_addr_o = base_q;
      mem_addr_o[OFF_W +: BEAT_W] = base_q[OFF_W +: BEAT_W] + beat_q;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      base_d      = base_q;
      data_d      = data_q;
      req_ready_o = 1'b0;
      mem_req_o   = 1'b0;
      push_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               base_d  = req_addr_i & ~OFF_MASK;
               beat_d  = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Holding off while full guarantees a free slot by the time we push.
            mem_req_o = !full_i;
            if (!full_i && mem_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               data_d  = mem_rdata_i;
               state_d = PUSH;
            end
         end
         PUSH: begin
            push_o = 1'b1;
            if (beat_q == LAST_BEAT) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end else begin
               beat_d  = beat_q + BEAT_W'(1);
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE);
   assign data_o = data_q;

endmodule

// File: doc/ucsbece154b_burst_pusher.md
UCSBECE154B_BURST_PUSHER -- requirements
Module: ucsbece154b_burst_pusher

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of memory read data and FIFO push data.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width.
REQ-003 Parameter BURST_LEN, default 4, SHALL set the words per burst; it is a power of two and at least 2.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  SHALL be the single clock; all flops are rising-edge.
REQ-006 rst_ni  in  1  SHALL be the asynchronous active-low reset.
REQ-007 req_valid_i  in  1  SHALL request a burst.
REQ-008 req_ready_o  out  1  SHALL indicate that a burst request is accepted this cycle.
REQ-009 req_addr_i  in  ADDR_WIDTH  SHALL carry the byte address of the critical word.
REQ-010 mem_req_o  out  1  SHALL be the memory single-word read request.
REQ-011 mem_addr_o  out  ADDR_WIDTH  SHALL be the word-aligned byte address of the current read.
REQ-012 mem_gnt_i  in  1  SHALL indicate that memory accepted mem_req_o this cycle.
REQ-013 mem_rvalid_i  in  1  SHALL indicate that mem_rdata_i holds the read response.
REQ-014 mem_rdata_i  in  DATA_WIDTH  SHALL carry the read response data.
REQ-015 push_o  out  1  SHALL push to the downstream FIFO push side.
REQ-016 data_o  out  DATA_WIDTH  SHALL carry the FIFO push data.
REQ-017 full_i  in  1  SHALL carry the downstream FIFO full flag.
REQ-018 busy_o  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-019 done_o  out  1  SHALL pulse for one cycle when a burst completes.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and PUSH, encoded in registers.
REQ-021 req_ready_o SHALL equal (state==IDLE).
- A handshake is req_valid_i && req_ready_o.
- On a handshake, latch base = req_addr_i with the low $clog2(DATA_WIDTH/8) bits zeroed, set beat=0, go to REQ.
REQ-022 Address: word index = (base word index + beat) mod BURST_LEN within the BURST_LEN-aligned block.
- Critical-word-first, wrap-around.
- Upper address bits SHALL equal those of base.
REQ-023 REQ: mem_req_o = !full_i; mem_addr_o driven from registers, stable until grant.
- mem_req_o && mem_gnt_i -> go to WAIT.
- full_i=1 -> stay in REQ with mem_req_o=0 (no request is issued while the FIFO is full).
REQ-024 WAIT: mem_req_o=0.
- mem_rvalid_i=1 -> capture mem_rdata_i into the data register, go to PUSH.
- Otherwise hold, with no timeout.
REQ-025 PUSH: push_o=1 for exactly one cycle, with data_o = the captured word.
- beat==BURST_LEN-1 -> done_o=1 in the same cycle, go to IDLE.
- Otherwise beat+1, go to REQ.
REQ-026 Only this block pushes to the FIFO, so full_i sampled low in REQ guarantees space at PUSH.
- push_o SHALL never assert in any state other than PUSH.
REQ-027 mem_rvalid_i SHALL be ignored outside WAIT; mem_gnt_i SHALL be ignored when mem_req_o=0.
REQ-028 Minimum latency with grant in the same cycle and rvalid one cycle later: 3 cycles per word, 3*BURST_LEN cycles from handshake to done_o.
REQ-029 data_o SHALL hold its last value outside PUSH.
REQ-030 The beat counter SHALL be $clog2(BURST_LEN) bits; no other counter wraps.

Reset
REQ-031 Asserting rst_ni low SHALL force, asynchronously and at any time including mid-burst: state=IDLE, beat=0, base=0, data register=0.
- Outputs while in reset: push_o=0, mem_req_o=0, done_o=0, busy_o=0, req_ready_o=1, data_o=0, mem_addr_o=0.
REQ-032 After rst_ni deasserts, the first handshake SHALL be accepted on the first rising edge.
- An interrupted burst is abandoned and not resumed; any late mem_rvalid_i is ignored.

Verification
REQ-033 Aligned burst, BURST_LEN=4, req_addr_i=0x100, grant in the same cycle, rvalid one cycle later with data 0xA0..0xA3 -> mem_addr_o 0x100, 0x104, 0x108, 0x10C; four push_o pulses carrying 0xA0..0xA3; done_o on the 12th cycle after the handshake.
REQ-034 Wrapped burst, req_addr_i=0x10B -> mem_addr_o 0x108, 0x10C, 0x100, 0x104.
REQ-035 Backpressure: hold full_i=1 for 5 cycles while in REQ -> mem_req_o=0 throughout, no push; the burst resumes the cycle after full_i falls and all 4 words still arrive in order.
REQ-036 Slow memory: mem_gnt_i delayed 3 cycles and mem_rvalid_i delayed 4 cycles -> mem_addr_o stable until grant; exactly one push per beat; spurious mem_rvalid_i pulses in IDLE or REQ cause no push.
REQ-037 Reset mid-burst after 2 pushes -> push_o, mem_req_o and busy_o fall immediately; a new request to 0x200 then completes normally with no done_o for the abandoned burst.
REQ-038 Back-to-back: req_valid_i held high -> a second handshake in the cycle after done_o, with no lost or duplicated beats.
